mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory stage of the 5-stage pipeline: consumes the M-side outputs of the execute stage, runs load/store
//  transactions on a req/gnt/rvalid data-memory bus, aligns/extends load data and holds the M/W pipeline
//  register. Stalls the front of the pipe (StallM) while a bus transaction is outstanding.
// PARAMETERS
//  XLEN     32  datapath width; only 32 supported (byte-enable width BE_W = XLEN/8 is a localparam)
//  REG_AW   5   register-index width
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-low reset
//  RegWriteM    in   1     instruction in M writes rd
//  MemWriteM    in   1     instruction in M is a store
//  ResultSrcM   in   2     00 ALU, 01 memory (load), 10 PC+4
//  Funct3M      in   3     access size/sign (RV32I load/store funct3)
//  ALUResultM   in   32    effective address / ALU result
//  WriteDataM   in   32    store data (unshifted)
//  PCPlus4M     in   32    PC+4 of instruction in M
//  RdM          in   5     destination register
//  dmem_req     out  1     request valid
//  dmem_we      out  1     1 store, 0 load
//  dmem_addr    out  32    word-aligned address {ALUResultM[31:2],2'b00}
//  dmem_be      out  4     byte enables
//  dmem_wdata   out  32    lane-replicated store data
//  dmem_gnt     in   1     request accepted this cycle
//  dmem_rvalid  in   1     load data valid (>=1 cycle after gnt)
//  dmem_rdata   in   32    load data
//  StallM       out  1     hold F/D/E/M registers this cycle
//  RegWriteW, ResultSrcW[2], ALUResultW[32], ReadDataW[32], PCPlus4W[32], RdW[5]   out   M/W register
// BEHAVIOUR
//  - Reset: FSM=IDLE; all W outputs 0; dmem_req=0 immediately (async); any later rvalid ignored in IDLE.
//  - memop = MemWriteM | (ResultSrcM==01). FSM states IDLE, WAIT.
//  - IDLE: dmem_req = memop (combinational). Store+gnt: done this cycle, stay IDLE. Load+gnt -> WAIT.
//    No gnt: req, addr, be, wdata held stable (inputs frozen by StallM) until gnt.
//  - WAIT: dmem_req=0; on dmem_rvalid: load done, -> IDLE. rvalid in same cycle as gnt is illegal.
//  - StallM = memop & ~done; done = (IDLE & MemWriteM & gnt) | (WAIT & rvalid). Min load latency 2 cycles.
//  - M/W register: if StallM -> bubble (RegWriteW=0, ResultSrcW=00, other W fields hold);
//    else load M fields; ReadDataW = extended rdata when load done, else hold.
//  - Store lanes: SB be=4'b0001<<a[1:0], wdata={4{b}}; SH be=a[1]?1100:0011, wdata={2{h}}; SW be=1111.
//  - Load extract: byte at a[1:0], half at a[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
//  - Unknown Funct3M treated as word access.
//  - Non-memory instructions pass M->W in one cycle, StallM=0, no bus activity.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: extra port MisalignW out 1. Half with a[0]=1 or word with a[1:0]!=0 is not
//   issued (dmem_req=0, no stall); passes to W with RegWriteW=0, MisalignW=1 for that one W cycle.
//  Undefined: no MisalignW port; low address bits beyond access size ignored (access forced aligned).
// STRUCTURE
//  Shared package riscv_pkg: RESULT_ALU/MEM/PC4 encodings, F3_B/H/W/BU/HU constants, lsu_state_t enum.
//  Sub-module lsu_load_ext (combinational: rdata, a[1:0], funct3 -> 32-bit extended load value).
// TESTING
//  SW addr 0x100 data 0xDEADBEEF, gnt same cycle -> be=1111, StallM=0, no W write (RegWriteW=0).
//  LB addr 0x103, gnt cycle 0, rvalid cycle 2 rdata 0x80xxxxxx -> StallM 2 cycles, ReadDataW=0xFFFFFF80.
//  LHU addr 0x102, rdata 0xBEEF1234 -> ReadDataW=0x0000BEEF; SH a=0x102 data 0x55AA -> be=1100, wdata 0x55AA55AA.
//  gnt withheld 3 cycles on a load -> req/addr stable, StallM=1 throughout, W receives bubbles (RegWriteW=0).
//  reset low while in WAIT -> req=0, W cleared; rvalid next cycle ignored, StallM=0.
//  MISALIGN_TRAP_EN: LW addr 0x101 -> no req, MisalignW=1, RegWriteW=0; undefined: req addr 0x100 be=1111.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings, access-size decode and LSU state type for the pipeline stages.
package riscv_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} accSize_t;
  typedef enum logic {LSU_IDLE, LSU_WAIT} lsu_state_t;

  // BU/HU are only meaningful for loads; any other encoding is a word access.
  function automatic accSize_t accessSize(input logic [2:0] funct3, input logic isStore);
    case (funct3)
      F3_B:    return SIZE_B;
      F3_H:    return SIZE_H;
      F3_BU:   return isStore ? SIZE_W : SIZE_B;
      F3_HU:   return isStore ? SIZE_W : SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: selects the addressed byte/half of the bus word and sign/zero-extends it.
module lsu_load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrLo,
  input  logic [2:0]  funct3,
  output logic [31:0] loadVal
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  assign byteVal = rdata[{addrLo, 3'b000} +: 8];
  assign halfVal = addrLo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (funct3)
      F3_B:    loadVal = {{24{byteVal[7]}}, byteVal};
      F3_BU:   loadVal = {24'b0, byteVal};
      F3_H:    loadVal = {{16{halfVal[15]}}, halfVal};
      F3_HU:   loadVal = {16'b0, halfVal};
      default: loadVal = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: drives the req/gnt/rvalid data bus, stalls while a transaction is open, holds M/W register.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses are not issued and flagged on MisalignW.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int REG_AW = 5,
  localparam int BE_W   = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [REG_AW-1:0] RdM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [BE_W-1:0]   dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              StallM,
`ifdef MISALIGN_TRAP_EN
  output logic              MisalignW,
`endif
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [XLEN-1:0]   ALUResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic [REG_AW-1:0] RdW
);

  lsu_state_t      state, stateNext;
  accSize_t        size;
  logic            isStore, isLoad, memop, misalign, issue;
  logic            reqRaw, done, loadDone;
  logic [1:0]      aLo;
  logic [XLEN-1:0] loadVal;

  assign isStore = MemWriteM;
  assign isLoad  = ~MemWriteM & (ResultSrcM == RESULT_MEM);
  assign memop   = isStore | isLoad;
  assign aLo     = ALUResultM[1:0];
  assign size    = accessSize(Funct3M, isStore);

`ifdef MISALIGN_TRAP_EN
  assign misalign = memop & (((size == SIZE_H) & aLo[0]) | ((size == SIZE_W) & (aLo != 2'b00)));
`else
  assign misalign = 1'b0;
`endif
  assign issue = memop & ~misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LSU_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    reqRaw    = 1'b0;
    done      = 1'b0;
    loadDone  = 1'b0;
    case (state)
      LSU_IDLE: begin
        reqRaw = issue;
        if (issue & dmem_gnt) begin
          if (isStore) done = 1'b1;
          else         stateNext = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (dmem_rvalid) begin
          done      = 1'b1;
          loadDone  = 1'b1;
          stateNext = LSU_IDLE;
        end
      end
      default: stateNext = LSU_IDLE;
    endcase
  end

  // Reset masks the request immediately, independent of the clock.
  assign dmem_req   = reqRaw & reset;
  assign StallM     = issue & ~done & reset;
  assign dmem_we    = isStore;
  assign dmem_addr  = {ALUResultM[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be    = {BE_W{1'b1}};
    dmem_wdata = WriteDataM;
    case (size)
      SIZE_B: begin
        dmem_be    = 4'b0001 << aLo;
        dmem_wdata = {4{WriteDataM[7:0]}};
      end
      SIZE_H: begin
        dmem_be    = aLo[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_ext uLoadExt (
    .rdata   (dmem_rdata),
    .addrLo  (aLo),
    .funct3  (Funct3M),
    .loadVal (loadVal)
  );

  // M/W pipeline register: bubble while stalled, otherwise capture M fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= RESULT_ALU;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= RESULT_ALU;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      RegWriteW  <= RegWriteM & ~misalign;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      if (loadDone) ReadDataW <= loadVal;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= misalign;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: random instruction stream against a size/offset arithmetic model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .StallM(StallM),
`ifdef MISALIGN_TRAP_EN
    .MisalignW(MisalignW),
`endif
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        memWrite;
    logic [1:0]  resSrc;
    logic        regWrite;
    logic [2:0]  f3;
    logic [31:0] alu, wd, pc4, rdata;
    logic [4:0]  rd;
    int          g, r;
    bit          spurious;
  } instr_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } busTxn_t;

  typedef struct {
    logic        regWrite, mis;
    logic [1:0]  resSrc;
    logic [31:0] alu, readData, pc4;
    logic [4:0]  rd;
  } wTxn_t;

  busTxn_t     busQ[$];
  wTxn_t       wQ[$];
  int          errors = 0;
  int          checks = 0;
  int          stallCyc = 0;
  int          reqCnt = 0;
  bit          monOn = 0;
  logic [31:0] lastAddr, lastWd, modelRead;
  logic [3:0]  lastBe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelSize(input logic [2:0] f3, input bit store);
    if (store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic int modelOffset(input logic [31:0] a, input int sz);
    int lo;
    lo = int'(a[1:0]);
    return lo - (lo % sz);
  endfunction

  function automatic bit modelMisaligned(input logic [31:0] a, input int sz);
`ifdef MISALIGN_TRAP_EN
    return (int'(a[1:0]) % sz) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] rdat, input logic [31:0] a,
                                            input logic [2:0] f3);
    int sz, off;
    logic [31:0] mask, v;
    sz   = modelSize(f3, 1'b0);
    off  = modelOffset(a, sz);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rdat >> (8 * off)) & mask;
    if (sz < 4 && f3[2] == 1'b0 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic instr_t mk(input logic mw, input logic [1:0] rs, input logic rw, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rdat,
                                input int g, input int r);
    instr_t t;
    t.memWrite = mw; t.resSrc = rs; t.regWrite = rw; t.f3 = f3;
    t.alu = alu; t.wd = wd; t.rdata = rdat; t.g = g; t.r = r;
    t.pc4 = $urandom; t.rd = 5'($urandom); t.spurious = 1'b0;
    return t;
  endfunction

  task automatic issue(input instr_t t);
    bit isSt, isLd, mis;
    int sz, off;
    busTxn_t b;
    wTxn_t w;
    isSt = t.memWrite;
    isLd = !t.memWrite && t.resSrc == 2'b01;
    sz   = modelSize(t.f3, isSt);
    off  = modelOffset(t.alu, sz);
    mis  = (isSt || isLd) && modelMisaligned(t.alu, sz);
    RegWriteM = t.regWrite; MemWriteM = t.memWrite; ResultSrcM = t.resSrc; Funct3M = t.f3;
    ALUResultM = t.alu; WriteDataM = t.wd; PCPlus4M = t.pc4; RdM = t.rd;
    if ((isSt || isLd) && !mis) begin
      b.we    = isSt;
      b.addr  = t.alu & 32'hFFFF_FFFC;
      b.be    = 4'(((1 << sz) - 1) << off);
      b.wdata = (sz == 1) ? (t.wd & 32'hFF) * 32'h0101_0101 :
                (sz == 2) ? (t.wd & 32'hFFFF) * 32'h0001_0001 : t.wd;
      busQ.push_back(b);
      if (isLd) modelRead = modelLoad(t.rdata, t.alu, t.f3);
    end
    w.regWrite = t.regWrite & ~mis; w.mis = mis; w.resSrc = t.resSrc;
    w.alu = t.alu; w.readData = modelRead; w.pc4 = t.pc4; w.rd = t.rd;
    wQ.push_back(w);
    if ((isSt || isLd) && !mis) begin
      dmem_gnt = 1'b0;
      repeat (t.g) begin @(posedge clk); #1; end
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      if (isLd) begin
        repeat (t.r - 1) begin dmem_rdata = $urandom; @(posedge clk); #1; end
        dmem_rvalid = 1'b1; dmem_rdata = t.rdata;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      end
    end else begin
      dmem_rvalid = t.spurious; dmem_rdata = $urandom;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
    end
  endtask

  // Monitor: W side advances whenever StallM was low before the edge; bus side checks every request cycle.
  initial begin
    bit prevValid, prevStall;
    wTxn_t w;
    busTxn_t b;
    prevValid = 0; prevStall = 0;
    forever begin
      @(negedge clk);
      if (!monOn) prevValid = 0;
      else begin
        if (prevValid) begin
          if (prevStall) begin
            chk("bubble_RegWriteW", {31'b0, RegWriteW}, 32'd0);
            chk("bubble_ResultSrcW", {30'b0, ResultSrcW}, 32'd0);
          end else if (wQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected: W advanced with no instruction expected at %0t", $time);
          end else begin
            w = wQ.pop_front();
            chk("RegWriteW", {31'b0, RegWriteW}, {31'b0, w.regWrite});
            chk("ResultSrcW", {30'b0, ResultSrcW}, {30'b0, w.resSrc});
            chk("ALUResultW", ALUResultW, w.alu);
            chk("ReadDataW", ReadDataW, w.readData);
            chk("PCPlus4W", PCPlus4W, w.pc4);
            chk("RdW", {27'b0, RdW}, {27'b0, w.rd});
`ifdef MISALIGN_TRAP_EN
            chk("MisalignW", {31'b0, MisalignW}, {31'b0, w.mis});
`endif
          end
        end
        if (StallM) stallCyc++;
        if (dmem_req) begin
          if (busQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_spurious: req with addr 0x%08h but none expected at %0t", dmem_addr, $time);
          end else begin
            b = busQ[0];
            chk("dmem_we", {31'b0, dmem_we}, {31'b0, b.we});
            chk("dmem_addr", dmem_addr, b.addr);
            if (b.we) begin
              chk("dmem_be", {28'b0, dmem_be}, {28'b0, b.be});
              chk("dmem_wdata", dmem_wdata, b.wdata);
            end
            if (dmem_gnt) begin
              void'(busQ.pop_front());
              lastAddr = dmem_addr; lastBe = dmem_be; lastWd = dmem_wdata;
              reqCnt++;
            end
          end
        end
        prevStall = StallM;
        prevValid = 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    instr_t t;
    int s0, r0, k;
    reset = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    modelRead = '0; lastAddr = '0; lastBe = '0; lastWd = '0;
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010;
    ALUResultM = 32'h200; WriteDataM = '0; PCPlus4M = 32'h44; RdM = 5'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req", {31'b0, dmem_req}, 32'd0);
    chk("reset_StallM", {31'b0, StallM}, 32'd0);
    chk("reset_RegWriteW", {31'b0, RegWriteW}, 32'd0);
    chk("reset_ResultSrcW", {30'b0, ResultSrcW}, 32'd0);
    chk("reset_ALUResultW", ALUResultW, 32'd0);
    chk("reset_ReadDataW", ReadDataW, 32'd0);
    chk("reset_PCPlus4W", PCPlus4W, 32'd0);
    chk("reset_RdW", {27'b0, RdW}, 32'd0);

    reset = 1'b1; monOn = 1'b1;

    s0 = stallCyc;
    issue(mk(1'b1, 2'b00, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1));
    chk("sw_stall_cycles", 32'(stallCyc - s0), 32'd0);
    chk("sw_be", {28'b0, lastBe}, 32'hF);
    chk("sw_no_write", {31'b0, RegWriteW}, 32'd0);

    s0 = stallCyc;
    issue(mk(1'b0, 2'b01, 1'b1, 3'b000, 32'h103, 32'h0, 32'h8012_3456, 0, 2));
    chk("lb_stall_cycles", 32'(stallCyc - s0), 32'd2);
    chk("lb_readdata", ReadDataW, 32'hFFFF_FF80);

    issue(mk(1'b0, 2'b01, 1'b1, 3'b101, 32'h102, 32'h0, 32'hBEEF_1234, 1, 1));
    chk("lhu_readdata", ReadDataW, 32'h0000_BEEF);

    issue(mk(1'b1, 2'b00, 1'b0, 3'b001, 32'h102, 32'h0000_55AA, 32'h0, 0, 1));
    chk("sh_be", {28'b0, lastBe}, 32'hC);
    chk("sh_wdata", lastWd, 32'h55AA_55AA);

    s0 = stallCyc; r0 = reqCnt;
    issue(mk(1'b0, 2'b01, 1'b1, 3'b010, 32'h204, 32'h0, 32'h1357_9BDF, 3, 1));
    chk("gnt_withheld_stall", 32'(stallCyc - s0), 32'd4);
    chk("gnt_withheld_reqs", 32'(reqCnt - r0), 32'd1);

    r0 = reqCnt;
    issue(mk(1'b0, 2'b01, 1'b1, 3'b010, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 1));
`ifdef MISALIGN_TRAP_EN
    chk("misalign_no_req", 32'(reqCnt - r0), 32'd0);
    chk("misalign_flag", {31'b0, MisalignW}, 32'd1);
    chk("misalign_no_write", {31'b0, RegWriteW}, 32'd0);
`else
    chk("lw_unaligned_reqs", 32'(reqCnt - r0), 32'd1);
    chk("lw_unaligned_addr", lastAddr, 32'h100);
    chk("lw_unaligned_be", {28'b0, lastBe}, 32'hF);
`endif

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 3);
      t = mk(1'b0, 2'b00, 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(1, 3));
      if (k == 1) t.resSrc = 2'b10;
      if (k == 2) begin t.resSrc = 2'b01; t.regWrite = 1'b1; end
      if (k == 3) begin t.memWrite = 1'b1; t.regWrite = 1'b0; t.resSrc = 2'($urandom_range(0, 2)); end
      t.spurious = (k < 2) && ($urandom_range(0, 2) == 0);
      issue(t);
    end
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
    @(negedge clk);
    monOn = 1'b0;
    chk("busQ_drained", busQ.size(), 32'd0);
    chk("wQ_drained", wQ.size(), 32'd0);

    // Reset asserted while a load waits for rvalid.
    @(posedge clk); #1;
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010;
    ALUResultM = 32'h300; PCPlus4M = 32'h88; RdM = 5'd3;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_StallM", {31'b0, StallM}, 32'd1);
    chk("wait_req", {31'b0, dmem_req}, 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_async_StallM", {31'b0, StallM}, 32'd0);
    chk("rst_async_PCPlus4W", PCPlus4W, 32'd0);
    chk("rst_async_ALUResultW", ALUResultW, 32'd0);
    RegWriteM = 1'b0; ResultSrcM = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("post_rst_StallM", {31'b0, StallM}, 32'd0);
    chk("post_rst_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("post_rst_rvalid_ignored", ReadDataW, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
